// File: rtl/register_file.sv
// Architectural integer register file with rename status.
// Commit write port from the ROB, rename write and two lookups for issue.
module register_file #(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int ROB_IDX_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 flush,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic [ROB_IDX_W-1:0] issue_rob_idx,
   input  logic [4:0]           rs1,
   output logic                 rs1_busy,
   output logic [ROB_IDX_W-1:0] rs1_tag,
   output logic [XLEN-1:0]      rs1_value,
   input  logic [4:0]           rs2,
   output logic                 rs2_busy,
   output logic [ROB_IDX_W-1:0] rs2_tag,
   output logic [XLEN-1:0]      rs2_value,
   input  logic                 rf_valid,
   input  logic [ROB_IDX_W-1:0] rf_index,
   input  logic [4:0]           rf_rd,
   input  logic [XLEN-1:0]      rf_value
);

   localparam int LW = 1 + ROB_IDX_W + XLEN;

   logic [XLEN-1:0]      regs_q [NREG];
   logic [XLEN-1:0]      regs_d [NREG];
   logic [NREG-1:0]      busy_q;
   logic [NREG-1:0]      busy_d;
   logic [ROB_IDX_W-1:0] tag_q  [NREG];
   logic [ROB_IDX_W-1:0] tag_d  [NREG];

   logic                 cmt_we;
   logic                 cmt_clr;
   logic                 ren_we;

   assign cmt_we  = rf_valid && (rf_rd != 5'd0);
   assign cmt_clr = cmt_we && busy_q[rf_rd] && (tag_q[rf_rd] == rf_index);
   assign ren_we  = !flush && issue_valid && (issue_rd != 5'd0);

   // Lookup of one source: x0, commit bypass, pending producer, or stored value.
   function automatic logic [LW-1:0] lookup(input logic [4:0] rs);
      logic [LW-1:0] r;
      r = '0;
      if (rs == 5'd0) begin
         r = '0;
      end else if (rf_valid && rf_rd == rs && busy_q[rs] &&
                   tag_q[rs] == rf_index) begin
         r = {1'b0, {ROB_IDX_W{1'b0}}, rf_value};
      end else if (busy_q[rs]) begin
         r = {1'b1, tag_q[rs], {XLEN{1'b0}}};
      end else begin
         r = {1'b0, {ROB_IDX_W{1'b0}}, regs_q[rs]};
      end
      return r;
   endfunction

   // Combinational operand lookups for both sources.
   always_comb begin
      {rs1_busy, rs1_tag, rs1_value} = lookup(rs1);
      {rs2_busy, rs2_tag, rs2_value} = lookup(rs2);
   end

   // Next state: commit write, busy clear, then flush or rename on top.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (cmt_we) begin
         regs_d[rf_rd] = rf_value;
      end
      if (cmt_clr) begin
         busy_d[rf_rd] = 1'b0;
      end
      if (flush) begin
         busy_d = '0;
      end else if (ren_we) begin
         busy_d[issue_rd] = 1'b1;
         tag_d[issue_rd]  = issue_rob_idx;
      end
   end

   // State update with synchronous active-low reset; rdy low freezes everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         busy_q <= '0;
      end else if (rdy) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
            tag_q[i]  <= tag_d[i];
         end
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file.
// Hand-computed expectations checked with immediate assertions.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, issue_valid, rf_valid;
   logic [4:0]  issue_rd, rs1, rs2, rf_rd;
   logic [5:0]  issue_rob_idx, rf_index;
   logic [31:0] rf_value;
   logic        rs1_busy, rs2_busy;
   logic [5:0]  rs1_tag, rs2_tag;
   logic [31:0] rs1_value, rs2_value;

   int n_assert = 0;
   int n_fail   = 0;

   register_file dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_rob_idx(issue_rob_idx),
      .rs1(rs1), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
      .rs1_value(rs1_value),
      .rs2(rs2), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
      .rs2_value(rs2_value),
      .rf_valid(rf_valid), .rf_index(rf_index), .rf_rd(rf_rd),
      .rf_value(rf_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; issue_valid = 0; rf_valid = 0;
   endtask

   initial begin
      rst = 0; rdy = 1; flush = 0; issue_valid = 0; rf_valid = 0;
      issue_rd = 0; issue_rob_idx = 0; rs1 = 0; rs2 = 0;
      rf_rd = 0; rf_index = 0; rf_value = 0;
      // 1 reset
      tick();
      rst = 1; rs1 = 5; rs2 = 31; #1;
      chk("rst_rs1_busy", rs1_busy, 0);
      chk("rst_rs1_tag", rs1_tag, 0);
      chk("rst_rs1_val", rs1_value, 0);
      chk("rst_rs2_busy", rs2_busy, 0);
      chk("rst_rs2_tag", rs2_tag, 0);
      chk("rst_rs2_val", rs2_value, 0);
      // 2 issue then commit with bypass
      issue_valid = 1; issue_rd = 3; issue_rob_idx = 7;
      tick();
      idle(); rs1 = 3; #1;
      chk("t2_busy", rs1_busy, 1);
      chk("t2_tag", rs1_tag, 7);
      chk("t2_val_busy", rs1_value, 0);
      rf_valid = 1; rf_rd = 3; rf_index = 7; rf_value = 32'hDEADBEEF; #1;
      chk("t2_byp_busy", rs1_busy, 0);
      chk("t2_byp_tag", rs1_tag, 0);
      chk("t2_byp_val", rs1_value, 32'hDEADBEEF);
      tick();
      idle(); #1;
      chk("t2_reg_busy", rs1_busy, 0);
      chk("t2_reg_val", rs1_value, 32'hDEADBEEF);
      // 3 stale commit leaves younger rename busy
      issue_valid = 1; issue_rd = 4; issue_rob_idx = 1;
      tick();
      issue_rob_idx = 2;
      tick();
      idle(); rs1 = 4;
      rf_valid = 1; rf_rd = 4; rf_index = 1; rf_value = 32'h11; #1;
      chk("t3_nobyp_busy", rs1_busy, 1);
      chk("t3_nobyp_tag", rs1_tag, 2);
      tick();
      idle(); #1;
      chk("t3_busy", rs1_busy, 1);
      chk("t3_tag", rs1_tag, 2);
      flush = 1;
      tick();
      idle(); #1;
      chk("t3_reg_val", rs1_value, 32'h11);
      // 4 same-cycle commit and rename of x6
      issue_valid = 1; issue_rd = 6; issue_rob_idx = 9;
      tick();
      idle(); rs1 = 6;
      rf_valid = 1; rf_rd = 6; rf_index = 9; rf_value = 32'h55;
      issue_valid = 1; issue_rd = 6; issue_rob_idx = 12; #1;
      chk("t4_byp_busy", rs1_busy, 0);
      chk("t4_byp_val", rs1_value, 32'h55);
      tick();
      idle(); #1;
      chk("t4_busy", rs1_busy, 1);
      chk("t4_tag", rs1_tag, 12);
      flush = 1;
      tick();
      idle(); #1;
      chk("t4_reg_val", rs1_value, 32'h55);
      // 5 flush together with commit and issue
      issue_valid = 1; issue_rd = 1; issue_rob_idx = 4;
      tick();
      issue_rd = 2; issue_rob_idx = 5;
      tick();
      issue_rd = 3; issue_rob_idx = 6;
      tick();
      idle(); rs1 = 1; rs2 = 3; #1;
      chk("t5_pre_tag1", rs1_tag, 4);
      chk("t5_pre_tag3", rs2_tag, 6);
      flush = 1; rf_valid = 1; rf_rd = 1; rf_index = 4; rf_value = 32'hA5;
      issue_valid = 1; issue_rd = 7; issue_rob_idx = 10;
      tick();
      idle(); #1;
      chk("t5_x1_busy", rs1_busy, 0);
      chk("t5_x1_val", rs1_value, 32'hA5);
      chk("t5_x3_busy", rs2_busy, 0);
      chk("t5_x3_val", rs2_value, 32'hDEADBEEF);
      rs1 = 2; rs2 = 7; #1;
      chk("t5_x2_busy", rs1_busy, 0);
      chk("t5_x7_busy", rs2_busy, 0);
      // 6 x0 and rdy freeze
      issue_valid = 1; issue_rd = 0; issue_rob_idx = 3;
      rf_valid = 1; rf_rd = 0; rf_index = 3; rf_value = 32'hFF;
      rs1 = 0; #1;
      chk("t6_x0_val_now", rs1_value, 0);
      chk("t6_x0_busy_now", rs1_busy, 0);
      tick();
      idle(); #1;
      chk("t6_x0_val", rs1_value, 0);
      chk("t6_x0_busy", rs1_busy, 0);
      chk("t6_x0_tag", rs1_tag, 0);
      rdy = 0; issue_valid = 1; issue_rd = 8; issue_rob_idx = 5;
      rf_valid = 1; rf_rd = 9; rf_index = 0; rf_value = 32'h99;
      tick();
      rdy = 1; idle(); rs1 = 9; rs2 = 8; #1;
      chk("t6_x8_busy", rs2_busy, 0);
      chk("t6_x9_val", rs1_value, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
